// File: rtl/ss_master.sv
// ss_master: save-state initiator. Walks the mapper register bank (0) then xram bank (1),
// copying every byte into (save) or back out of (load) a linear image in buffer memory.
module ss_master #(
    parameter int REG_LEN    = 128,
    parameter int REG_WR_LEN = 31,
    parameter int XRAM_LEN   = 1024,
    parameter int RD_LAT     = 2,
    parameter int STB_LEN    = 4
) (
    input  logic        clk,
    input  logic        map_rst,
    input  logic        start,
    input  logic        dir,
    output logic        busy,
    output logic        done,
    output logic        ss_act,
    output logic [7:0]  ss_bank,
    output logic [9:0]  ss_addr,
    output logic        ss_we,
    output logic        ss_wr_req,
    output logic [7:0]  ss_wdat,
    input  logic [7:0]  ss_rdat,
    output logic        mem_req,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [7:0]  mem_wdat,
    input  logic [7:0]  mem_rdat,
    input  logic        mem_ack
);
    localparam logic [10:0] LAST_IDX = 11'(REG_LEN + XRAM_LEN - 1);
    localparam logic [10:0] REG_END  = 11'(REG_LEN);
    localparam logic [10:0] WR_END   = 11'(REG_WR_LEN);
    localparam logic [3:0]  RD_LAST  = 4'(RD_LAT - 1);
    localparam logic [3:0]  STB_LAST = 4'(STB_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, MAP_RD, MEM_WR, MEM_RD, MAP_WR, NEXT, FIN
    } state_t;

    state_t      state, state_nx;
    logic [10:0] idx;
    logic [3:0]  cnt;
    logic        dir_q;
    logic [7:0]  rd_byte;
    logic [7:0]  wr_byte;
    logic        in_xram;
    logic        wr_ok;
    logic        is_last;

    assign in_xram = idx >= REG_END;
    // Registers at and above REG_WR_LEN are status/map index and must not be restored.
    assign wr_ok   = in_xram || (idx < WR_END);
    assign is_last = idx == LAST_IDX;

    always_ff @(posedge clk) begin
        if (map_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            idx     <= '0;
            cnt     <= '0;
            dir_q   <= 1'b0;
            rd_byte <= '0;
            wr_byte <= '0;
        end else begin
            cnt <= (state == MAP_RD || state == MAP_WR) ? cnt + 4'd1 : 4'd0;
            case (state)
                IDLE: if (start) begin
                    idx   <= '0;
                    dir_q <= dir;
                end
                MAP_RD: if (cnt == RD_LAST) rd_byte <= ss_rdat;
                MEM_RD: if (mem_ack) wr_byte <= mem_rdat;
                NEXT:   if (!is_last) idx <= idx + 11'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        done      = 1'b0;
        ss_we     = 1'b0;
        ss_wr_req = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE:   if (start) state_nx = SETUP;
            SETUP:  state_nx = dir_q ? MEM_RD : MAP_RD;
            MAP_RD: if (cnt == RD_LAST) state_nx = MEM_WR;
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_nx = NEXT;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ack) state_nx = wr_ok ? MAP_WR : NEXT;
            end
            MAP_WR: begin
                ss_we     = !in_xram;
                ss_wr_req = in_xram;
                if (cnt == STB_LAST) state_nx = NEXT;
            end
            NEXT:   state_nx = is_last ? FIN : SETUP;
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        busy     = state != IDLE;
        ss_act   = state != IDLE;
        ss_bank  = {7'd0, in_xram};
        ss_addr  = in_xram ? 10'(idx - REG_END) : idx[9:0];
        ss_wdat  = wr_byte;
        mem_addr = idx;
        mem_wdat = rd_byte;

        // Reset silences the bus in the same cycle so an abort never issues one more strobe or request.
        if (map_rst) begin
            state_nx  = IDLE;
            busy      = 1'b0;
            done      = 1'b0;
            ss_act    = 1'b0;
            ss_bank   = '0;
            ss_addr   = '0;
            ss_we     = 1'b0;
            ss_wr_req = 1'b0;
            ss_wdat   = '0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdat  = '0;
        end
    end
endmodule

// File: tb/tb_ss_master.sv
// tb_ss_master: drives a default-size ss_master and a tiny fast-timing one, checking each
// buffer transfer and mapper strobe against a byte-indexed model of the save-state image.
module tb_ss_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2], start [2], dir [2];
    logic        busy [2], done [2], ss_act [2], ss_we [2], ss_wr_req [2];
    logic        mem_req [2], mem_we [2], mem_ack [2];
    logic [7:0]  ss_bank [2], ss_wdat [2], ss_rdat [2], mem_wdat [2], mem_rdat [2];
    logic [9:0]  ss_addr [2];
    logic [10:0] mem_addr [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ss_master #(
            .REG_LEN   (k ? 8 : 128),
            .REG_WR_LEN(k ? 3 : 31),
            .XRAM_LEN  (k ? 16 : 1024),
            .RD_LAT    (k ? 1 : 2),
            .STB_LEN   (k ? 1 : 4)
        ) u_dut (
            .clk      (clk),
            .map_rst  (rst[k]),
            .start    (start[k]),
            .dir      (dir[k]),
            .busy     (busy[k]),
            .done     (done[k]),
            .ss_act   (ss_act[k]),
            .ss_bank  (ss_bank[k]),
            .ss_addr  (ss_addr[k]),
            .ss_we    (ss_we[k]),
            .ss_wr_req(ss_wr_req[k]),
            .ss_wdat  (ss_wdat[k]),
            .ss_rdat  (ss_rdat[k]),
            .mem_req  (mem_req[k]),
            .mem_we   (mem_we[k]),
            .mem_addr (mem_addr[k]),
            .mem_wdat (mem_wdat[k]),
            .mem_rdat (mem_rdat[k]),
            .mem_ack  (mem_ack[k])
        );
    end

    function automatic int p_rl(int k);  return k ? 8 : 128;   endfunction
    function automatic int p_wl(int k);  return k ? 3 : 31;    endfunction
    function automatic int p_xl(int k);  return k ? 16 : 1024; endfunction
    function automatic int p_rd(int k);  return k ? 1 : 2;     endfunction
    function automatic int p_stb(int k); return k ? 1 : 4;     endfunction
    function automatic int p_n(int k);   return p_rl(k) + p_xl(k); endfunction
    function automatic int nwr(int k);   return p_wl(k) + p_xl(k); endfunction
    function automatic int bank_of(int k, int i); return (i >= p_rl(k)) ? 1 : 0; endfunction
    function automatic int addr_of(int k, int i); return (i >= p_rl(k)) ? i - p_rl(k) : i; endfunction
    function automatic bit writable(int k, int i); return bank_of(k, i) == 1 || i < p_wl(k); endfunction
    // Mapper returns its low address byte XOR bank.
    function automatic int sv_exp(int k, int i); return (addr_of(k, i) & 255) ^ bank_of(k, i); endfunction
    function automatic int save_cycles(int k); return p_n(k) * (3 + p_rd(k)) + 2; endfunction
    function automatic int load_cycles(int k);
        return 2 + nwr(k) * (3 + p_stb(k)) + (p_n(k) - nwr(k)) * 3;
    endfunction

    function automatic int outs_any(int k);
        return int'(busy[k] | done[k] | ss_act[k] | ss_we[k] | ss_wr_req[k] | mem_req[k] | mem_we[k]
                    | (|ss_bank[k]) | (|ss_addr[k]) | (|ss_wdat[k]) | (|mem_addr[k]) | (|mem_wdat[k]));
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_start = 0;

    int          op_dir [2], maxd [2], mdelay [2], mwait [2];
    int          wr_i [2], rd_i [2], ev_i [2], n_str [2], done_n [2], t_done [2];
    int          stable [2], run_len [2];
    logic        prev_req [2], prev_ack [2], prev_we [2], prev_str [2], run_kind [2];
    logic [10:0] prev_maddr [2];
    logic [9:0]  last_addr [2], run_addr [2];
    logic [7:0]  last_bank [2], run_bank [2], run_dat [2];
    logic [7:0]  img [2][1152];
    logic [7:0]  cap [2][1152];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle of observation for instance k, then drive the mapper and buffer responses.
    task automatic mon(input int k);
        logic s;
        logic ack;
        if (rst[k]) begin
            chk("rst_outs", outs_any(k), 0);
            prev_req[k] = 1'b0;
            prev_ack[k] = 1'b0;
            prev_str[k] = 1'b0;
            mwait[k]    = 0;
            stable[k]   = 0;
            mem_ack[k]  = 1'b0;
            mem_rdat[k] = 8'($urandom);
            ss_rdat[k]  = 8'($urandom);
        end else begin
            chk("act_busy", int'(ss_act[k]), int'(busy[k]));
            if (done[k]) begin
                done_n[k]++;
                t_done[k] = cyc;
                chk("done_busy", int'(busy[k]), 1);
            end

            if (ss_addr[k] == last_addr[k] && ss_bank[k] == last_bank[k]) stable[k]++;
            else stable[k] = 1;
            last_addr[k] = ss_addr[k];
            last_bank[k] = ss_bank[k];
            ss_rdat[k] = (stable[k] > p_rd(k)) ? (ss_addr[k][7:0] ^ ss_bank[k]) : 8'($urandom);

            s = ss_we[k] | ss_wr_req[k];
            if (s && !prev_str[k]) begin
                chk("strobe_dir", op_dir[k], 1);
                chk("dual_strobe", int'(ss_we[k] & ss_wr_req[k]), 0);
                while (ev_i[k] < p_n(k) && !writable(k, ev_i[k])) ev_i[k]++;
                if (ev_i[k] < p_n(k)) begin
                    chk("str_addr", int'(ss_addr[k]), addr_of(k, ev_i[k]));
                    chk("str_bank", int'(ss_bank[k]), bank_of(k, ev_i[k]));
                    chk("str_kind", int'(ss_wr_req[k]), bank_of(k, ev_i[k]));
                    chk("str_data", int'(ss_wdat[k]), int'(img[k][ev_i[k]]));
                end else begin
                    chk("extra_strobe", ev_i[k], p_n(k) - 1);
                end
                run_len[k]  = 1;
                run_addr[k] = ss_addr[k];
                run_bank[k] = ss_bank[k];
                run_dat[k]  = ss_wdat[k];
                run_kind[k] = ss_wr_req[k];
            end else if (s) begin
                run_len[k]++;
                chk("str_stable", int'(ss_addr[k] != run_addr[k] || ss_bank[k] != run_bank[k]
                                       || ss_wdat[k] != run_dat[k] || ss_wr_req[k] != run_kind[k]), 0);
            end else if (prev_str[k]) begin
                chk("str_width", run_len[k], p_stb(k));
                n_str[k]++;
                ev_i[k]++;
            end
            prev_str[k] = s;

            if (prev_req[k] && !prev_ack[k])
                chk("req_held", int'({mem_req[k], mem_we[k], mem_addr[k]}),
                                int'({1'b1, prev_we[k], prev_maddr[k]}));
            if (prev_ack[k]) chk("req_drop", int'(mem_req[k]), 0);
            ack = 1'b0;
            if (mem_req[k]) begin
                if (mwait[k] >= mdelay[k]) begin
                    ack = 1'b1;
                    if (mem_we[k]) begin
                        chk("wr_dir", op_dir[k], 0);
                        chk("wr_addr", int'(mem_addr[k]), wr_i[k]);
                        chk("wr_data", int'(mem_wdat[k]), sv_exp(k, wr_i[k]));
                        if (int'(mem_addr[k]) < p_n(k)) cap[k][mem_addr[k]] = mem_wdat[k];
                        wr_i[k]++;
                    end else begin
                        chk("rd_dir", op_dir[k], 1);
                        chk("rd_addr", int'(mem_addr[k]), rd_i[k]);
                        rd_i[k]++;
                    end
                end else begin
                    mwait[k]++;
                end
            end else begin
                mwait[k]  = 0;
                mdelay[k] = int'($urandom_range(maxd[k], 0));
            end
            mem_ack[k]  = ack;
            mem_rdat[k] = (ack && int'(mem_addr[k]) < p_n(k)) ? img[k][mem_addr[k]] : 8'($urandom);
            prev_req[k]   = mem_req[k];
            prev_ack[k]   = ack;
            prev_we[k]    = mem_we[k];
            prev_maddr[k] = mem_addr[k];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mon(0);
        mon(1);
    endtask

    task automatic clr_op(input int k, input int d, input int md);
        op_dir[k] = d;
        maxd[k]   = md;
        wr_i[k]   = 0;
        rd_i[k]   = 0;
        ev_i[k]   = 0;
        n_str[k]  = 0;
        done_n[k] = 0;
        t_done[k] = 0;
    endtask

    // Full operation with spurious start pulses and dir toggling while busy.
    task automatic run_op(input int k, input int d, input int md);
        int n;
        clr_op(k, d, md);
        start[k] = 1'b1;
        dir[k]   = (d != 0);
        t_start  = cyc;
        n = 0;
        do begin
            tick();
            n++;
            start[k] = (done_n[k] == 0) && ($urandom_range(7, 0) == 0);
            dir[k]   = 1'($urandom);
        end while (done_n[k] == 0 && n < 30000);
        chk("op_done", int'(done_n[k] > 0), 1);
        start[k] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("done_once", done_n[k], 1);
        chk("idle_after", int'(busy[k]), 0);
        if (md == 0)
            chk("latency", t_done[k] - t_start + 1, d ? load_cycles(k) : save_cycles(k));
        if (d == 0) begin
            chk("wr_count", wr_i[k], p_n(k));
        end else begin
            chk("rd_count", rd_i[k], p_n(k));
            chk("str_count", n_str[k], nwr(k));
        end
        op_dir[k] = 2;
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; start[k] = 1'b0; dir[k] = 1'b0;
            mem_ack[k] = 1'b0; mem_rdat[k] = '0; ss_rdat[k] = '0;
            clr_op(k, 2, 0);
            mdelay[k] = 0; mwait[k] = 0; stable[k] = 0; run_len[k] = 0;
            prev_req[k] = 1'b0; prev_ack[k] = 1'b0; prev_we[k] = 1'b0; prev_str[k] = 1'b0;
            run_kind[k] = 1'b0; prev_maddr[k] = '0; last_addr[k] = '0; run_addr[k] = '0;
            last_bank[k] = '0; run_bank[k] = '0; run_dat[k] = '0;
            for (int i = 0; i < 1152; i++) begin
                img[k][i] = 8'(i);
                cap[k][i] = '0;
            end
        end
        repeat (3) tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();
        chk("reset_outs0", outs_any(0), 0);
        chk("reset_outs1", outs_any(1), 0);

        run_op(0, 0, 0);
        chk("img_5", int'(cap[0][5]), 'h05);
        chk("img_128", int'(cap[0][128]), 'h01);
        chk("img_1151", int'(cap[0][1151]), 'hFE);
        run_op(0, 1, 0);
        run_op(0, 0, 7);
        for (int i = 0; i < 1152; i++) img[0][i] = 8'($urandom);
        run_op(0, 1, 7);

        clr_op(0, 1, 0);
        start[0] = 1'b1;
        dir[0]   = 1'b1;
        n = 0;
        do begin
            tick();
            start[0] = 1'b0;
            n++;
        end while (mem_addr[0] != 11'd600 && n < 20000);
        chk("abort_reached", int'(mem_addr[0]), 600);
        rst[0]    = 1'b1;
        op_dir[0] = 2;
        #1;
        chk("abort_outs_now", outs_any(0), 0);
        tick();
        rst[0] = 1'b0;
        tick();
        chk("abort_outs_after", outs_any(0), 0);
        for (int i = 0; i < 20; i++) tick();
        chk("abort_no_done", done_n[0], 0);
        run_op(0, 1, 0);

        rst[1]   = 1'b1;
        start[1] = 1'b1;
        tick();
        rst[1]   = 1'b0;
        start[1] = 1'b0;
        tick();
        tick();
        chk("rst_beats_start", int'(busy[1]), 0);
        run_op(1, 0, 0);
        run_op(1, 1, 0);
        run_op(1, 0, 7);
        for (int i = 0; i < 1152; i++) img[1][i] = 8'($urandom);
        run_op(1, 1, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
